// File: rtl/mcpu_prog_loader_if.sv
// Stream and RAM write-port bundle between a word source and mcpu_prog_loader.
// The loader side uses the slave modport; the source / RAM side uses master.
interface mcpu_prog_loader_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
);
    // s_valid/s_ready: a word transfers on every rising edge where both are high.
    // s_data/s_last are meaningful only with s_valid; s_ready never depends on s_valid.
    logic                 s_valid;
    logic                 s_ready;
    logic [WORD_SIZE-1:0] s_data;
    logic                 s_last;

    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mcpu_prog_loader.sv
// MCPU program loader: holds the CPU in reset, zeroes RAM, streams an image in, then releases the CPU.
// Optional macro MCPU_LOADER_CHECKSUM_EN enables the running modular checksum (tied to 0 otherwise).
module mcpu_prog_loader #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8,
    parameter int RAM_SIZE  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    mcpu_prog_loader_if.slave    bus,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_SIZE:0]   word_count,
    output logic [WORD_SIZE-1:0] checksum,
    output logic [2:0]           fsm_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [ADDR_SIZE:0]   RAM_WORDS = (ADDR_SIZE+1)'(RAM_SIZE);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_SIZE - 1);

    state_t               state, state_d;
    logic                 ready_q, ready_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 cpu_reset_d, busy_d, done_d, error_d;
    logic [ADDR_SIZE:0]   count_d;
    logic [WORD_SIZE-1:0] checksum_d;
    logic                 accept;

    assign accept = bus.s_valid & ready_q;

    always_comb begin
        state_d    = state;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        error_d    = error;
        count_d    = word_count;
        checksum_d = checksum;

        case (state)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d    = CLEAR;
                    we_d       = 1'b1;
                    addr_d     = '0;
                    wdata_d    = '0;
                    error_d    = 1'b0;
                    count_d    = '0;
                    checksum_d = '0;
                end
            end
            CLEAR: begin
                // The clear pointer is the visible write address itself.
                if (addr_q == LAST_ADDR) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_SIZE'(1);
                end
            end
            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = word_count[ADDR_SIZE-1:0];
                    wdata_d = bus.s_data;
                    count_d = word_count + (ADDR_SIZE+1)'(1);
`ifdef MCPU_LOADER_CHECKSUM_EN
                    checksum_d = checksum + bus.s_data;
`endif
                    if (bus.s_last) begin
                        state_d = RUN;
                    end
                end else if (bus.s_valid && (word_count == RAM_WORDS)) begin
                    // RAM is full: the extra word is dropped, never written.
                    state_d = ERR;
                    error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        ready_d     = (state_d == LOAD) && (count_d < RAM_WORDS);
        busy_d      = (state_d == CLEAR) || (state_d == LOAD);
        cpu_reset_d = (state_d != RUN);
        done_d      = (state_d == RUN) && (state != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            state      <= state_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_reset  <= cpu_reset_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            word_count <= count_d;
            checksum   <= checksum_d;
        end
    end

    assign bus.s_ready   = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign fsm_state     = state;
endmodule
